// File: rtl/spi_temp_sensor_slave.sv
// ---------------------------------------------------------------------------
// spi_temp_sensor_slave
//
// LM70-style SPI temperature sensor slave. It oversamples the SPI pins on the
// system clock. Each frame shifts out a temperature snapshot, or the ID code
// while in shutdown, MSB first. It then shifts in a host command word. A
// complete command equal to SHUTDOWN_CMD puts the device in shutdown. Any
// other complete command takes it out of shutdown.
//
// Ports:
//   clk         system clock (>= 8x SCK)
//   rst_n       asynchronous active-low reset
//   CS          SPI chip select, active low (asynchronous)
//   SCK         SPI serial clock (asynchronous)
//   SI          serial data from host
//   SO          serial data to host
//   SO_OE       SO drive enable, high for the duration of a frame
//   temp_in     new temperature value
//   temp_valid  one-clk strobe loading temp_in into the temperature register
//   shutdown    device is in shutdown
//   cmd_out     last complete command received
//   cmd_valid   one-clk pulse when cmd_out updates
//   busy        frame in progress
// ---------------------------------------------------------------------------
module spi_temp_sensor_slave #(
    parameter int                DATA_W       = 16,
    parameter int                CMD_W        = 16,
    parameter logic [DATA_W-1:0] TEMP_RESET   = 16'h44C0,
    parameter logic [DATA_W-1:0] ID_CODE      = 16'h8001,
    parameter logic [CMD_W-1:0]  SHUTDOWN_CMD = 16'h00FF,
    parameter bit                CPOL         = 1'b0,
    parameter bit                CPHA         = 1'b0,
    parameter int                SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CS,
    input  logic              SCK,
    input  logic              SI,
    output logic              SO,
    output logic              SO_OE,
    input  logic [DATA_W-1:0] temp_in,
    input  logic              temp_valid,
    output logic              shutdown,
    output logic [CMD_W-1:0]  cmd_out,
    output logic              cmd_valid,
    output logic              busy
);

    localparam int MAX_W = (DATA_W > CMD_W) ? DATA_W : CMD_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CMD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Synchroniser chains and previous-sample registers
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] si_sync_q;
    logic                   cs_prev_q;
    logic                   eff_prev_q;

    // Frame state
    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [DATA_W-1:0]  shift_q,     shift_d;
    logic [CMD_W-1:0]   cmd_shift_q, cmd_shift_d;
    logic               first_q,     first_d;
    logic [DATA_W-1:0]  temp_q,      temp_d;

    // Registered outputs
    logic               so_q,        so_d;
    logic               so_oe_q,     so_oe_d;
    logic               shutdown_q,  shutdown_d;
    logic [CMD_W-1:0]   cmd_out_q,   cmd_out_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               busy_q,      busy_d;

    logic              cs_s;
    logic              eff_s;
    logic              si_s;
    logic              cs_fall_s;
    logic              cs_rise_s;
    logic              lead_s;
    logic              trail_s;
    logic              sample_s;
    logic              launch_s;
    logic [DATA_W-1:0] snap_s;

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign eff_s = sck_sync_q[SYNC_STAGES-1] ^ CPOL;
    assign si_s  = si_sync_q[SYNC_STAGES-1];

    // The CS chain resets low. A CS held low through reset therefore never
    // looks like a fresh fall, and a frame needs a genuine high-to-low edge.
    assign cs_fall_s = cs_prev_q & ~cs_s;
    assign cs_rise_s = ~cs_prev_q & cs_s;
    assign lead_s    = eff_s & ~eff_prev_q;
    assign trail_s   = ~eff_s & eff_prev_q;
    assign sample_s  = CPHA ? trail_s : lead_s;
    assign launch_s  = CPHA ? lead_s : trail_s;

    // Shutdown selects the ID word for the snapshot taken at CS fall.
    assign snap_s = shutdown_q ? ID_CODE : temp_q;

    // Pin synchronisers and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= '0;
            sck_sync_q <= {SYNC_STAGES{CPOL}};
            si_sync_q  <= '0;
            cs_prev_q  <= 1'b0;
            eff_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], SI};
            cs_prev_q  <= cs_s;
            eff_prev_q <= eff_s;
        end
    end

    // Next-state and output logic for the frame FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        cmd_shift_d = cmd_shift_q;
        first_d     = first_q;
        so_d        = so_q;
        so_oe_d     = so_oe_q;
        shutdown_d  = shutdown_q;
        cmd_out_d   = cmd_out_q;
        cmd_valid_d = 1'b0;

        if (temp_valid) begin
            temp_d = temp_in;
        end else begin
            temp_d = temp_q;
        end

        if (cs_rise_s) begin
            state_d = ST_IDLE;
            so_d    = 1'b0;
            so_oe_d = 1'b0;
            // Only a fully received command is committed.
            if (state_q == ST_DONE) begin
                cmd_out_d   = cmd_shift_q;
                cmd_valid_d = 1'b1;
                shutdown_d  = (cmd_shift_q == SHUTDOWN_CMD);
            end else begin
                cmd_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_d     = ST_DATA;
                        shift_d     = snap_s;
                        cnt_d       = '0;
                        cmd_shift_d = '0;
                        first_d     = 1'b1;
                        so_oe_d     = 1'b1;
                        so_d        = CPHA ? 1'b0 : snap_s[DATA_W-1];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // In CPHA=1 the first launch edge presents the MSB unshifted.
                    if (launch_s) begin
                        if (CPHA && first_q) begin
                            so_d    = shift_q[DATA_W-1];
                            first_d = 1'b0;
                        end else begin
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                            so_d    = shift_q[DATA_W-2];
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                    if (sample_s) begin
                        if (cnt_q == DATA_LAST) begin
                            state_d = ST_CMD;
                            cnt_d   = '0;
                            so_d    = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_CMD: begin
                    so_d = 1'b0;
                    if (sample_s) begin
                        cmd_shift_d = {cmd_shift_q[CMD_W-2:0], si_s};
                        if (cnt_q == CMD_LAST) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DONE: begin
                    so_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    so_d    = 1'b0;
                    so_oe_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            cmd_shift_q <= '0;
            first_q     <= 1'b0;
            temp_q      <= TEMP_RESET;
            so_q        <= 1'b0;
            so_oe_q     <= 1'b0;
            shutdown_q  <= 1'b0;
            cmd_out_q   <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            cmd_shift_q <= cmd_shift_d;
            first_q     <= first_d;
            temp_q      <= temp_d;
            so_q        <= so_d;
            so_oe_q     <= so_oe_d;
            shutdown_q  <= shutdown_d;
            cmd_out_q   <= cmd_out_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign SO        = so_q;
    assign SO_OE     = so_oe_q;
    assign shutdown  = shutdown_q;
    assign cmd_out   = cmd_out_q;
    assign cmd_valid = cmd_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_temp_sensor_slave.sv
// ---------------------------------------------------------------------------
// Testbench for spi_temp_sensor_slave. One instance is built per SPI mode
// (index = {CPOL,CPHA}). A host task drives each instance. A per-mode model
// tracks temperature, shutdown, last command and cmd_valid pulse count.
// ---------------------------------------------------------------------------
module tb_spi_temp_sensor_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cs, sck, si, so, so_oe, temp_valid, shutdown, cmd_valid, busy;
    logic [15:0] temp_in [4];
    logic [15:0] cmd_out [4];

    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;

    // Behavioural model, one entry per mode
    logic [15:0] mdl_temp [4];
    bit          mdl_sd   [4];
    logic [15:0] mdl_cmd  [4];
    int          mdl_cv   [4];
    int          cv_cnt   [4];
    logic [15:0] last_rd;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_temp_sensor_slave #(
            .CPOL(((g / 2) % 2) == 1),
            .CPHA((g % 2) == 1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .CS         (cs[g]),
            .SCK        (sck[g]),
            .SI         (si[g]),
            .SO         (so[g]),
            .SO_OE      (so_oe[g]),
            .temp_in    (temp_in[g]),
            .temp_valid (temp_valid[g]),
            .shutdown   (shutdown[g]),
            .cmd_out    (cmd_out[g]),
            .cmd_valid  (cmd_valid[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic load_temp(input int m, input logic [15:0] v);
        @(negedge clk);
        temp_in[m]    = v;
        temp_valid[m] = 1'b1;
        @(negedge clk);
        temp_valid[m] = 1'b0;
        mdl_temp[m]   = v;
    endtask

    // Host frame: nclk SCK cycles, command shifted out after 16 data clocks,
    // SO sampled on the mode's sample edge into last_rd.
    task automatic do_frame(input int m, input int nclk, input logic [15:0] cmd,
                            input bit mid_en, input logic [15:0] mid_val);
        logic [15:0] rd;
        logic [15:0] exp_word;
        logic [31:0] tx;
        bit          cpol;
        bit          cpha;
        cpol     = ((m / 2) % 2) == 1;
        cpha     = (m % 2) == 1;
        tx       = {16'h0000, cmd};
        rd       = 16'h0000;
        exp_word = mdl_sd[m] ? 16'h8001 : mdl_temp[m];
        @(negedge clk);
        cs[m] = 1'b0;
        half();
        chk($sformatf("so_oe_in_frame_m%0d", m), {31'd0, so_oe[m]}, 32'd1);
        chk($sformatf("busy_in_frame_m%0d", m), {31'd0, busy[m]}, 32'd1);
        for (int i = 0; i < nclk; i++) begin
            if (mid_en && i == 5) load_temp(m, mid_val);
            if (!cpha) si[m] = (i < 32) ? tx[31 - i] : 1'b0;
            if (!cpha && i < 16) rd = {rd[14:0], so[m]};
            sck[m] = ~cpol;
            if (cpha) si[m] = (i < 32) ? tx[31 - i] : 1'b0;
            half();
            if (cpha && i < 16) rd = {rd[14:0], so[m]};
            sck[m] = cpol;
            half();
        end
        cs[m]  = 1'b1;
        si[m]  = 1'b0;
        chk_en = 1'b0;
        repeat (6) @(negedge clk);
        if (nclk >= 32) begin
            mdl_cmd[m] = cmd;
            mdl_sd[m]  = (cmd == 16'h00FF);
            mdl_cv[m]  = mdl_cv[m] + 1;
        end
        chk_en  = 1'b1;
        last_rd = rd;
        if (nclk >= 16) chk($sformatf("frame_data_m%0d", m), {16'd0, rd}, {16'd0, exp_word});
        chk($sformatf("busy_after_m%0d", m), {31'd0, busy[m]}, 32'd0);
        chk($sformatf("so_oe_after_m%0d", m), {31'd0, so_oe[m]}, 32'd0);
        chk($sformatf("so_after_m%0d", m), {31'd0, so[m]}, 32'd0);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            mdl_temp[m] = 16'h44C0;
            mdl_sd[m]   = 1'b0;
            mdl_cmd[m]  = 16'h0000;
        end
    endtask

    // cmd_valid pulse counter; a pulse wider than one clk counts twice
    initial begin
        for (int m = 0; m < 4; m++) cv_cnt[m] = 0;
        forever begin
            @(posedge clk);
            for (int m = 0; m < 4; m++) if (cmd_valid[m] === 1'b1) cv_cnt[m]++;
        end
    end

    // Per-cycle comparison of persistent outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int m = 0; m < 4; m++) begin
                    chk($sformatf("shutdown_m%0d", m), {31'd0, shutdown[m]}, {31'd0, mdl_sd[m]});
                    chk($sformatf("cmd_out_m%0d", m), {16'd0, cmd_out[m]}, {16'd0, mdl_cmd[m]});
                    chk($sformatf("cmd_valid_cnt_m%0d", m), cv_cnt[m], mdl_cv[m]);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        cs         = 4'b1111;
        sck        = 4'b1100;
        si         = 4'b0000;
        temp_valid = 4'b0000;
        for (int m = 0; m < 4; m++) begin
            temp_in[m] = 16'h0000;
            mdl_cv[m]  = 0;
        end
        model_reset();
        repeat (4) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk("reset_so", {31'd0, so[m]}, 32'd0);
            chk("reset_so_oe", {31'd0, so_oe[m]}, 32'd0);
            chk("reset_busy", {31'd0, busy[m]}, 32'd0);
            chk("reset_shutdown", {31'd0, shutdown[m]}, 32'd0);
            chk("reset_cmd_out", {16'd0, cmd_out[m]}, 32'd0);
            chk("reset_cmd_valid", {31'd0, cmd_valid[m]}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;

        // Reset temperature, 16-clock frame
        do_frame(0, 16, 16'h0000, 1'b0, 16'h0000);
        chk("lit_reset_temp", {16'd0, last_rd}, 32'h0000_44C0);
        chk("lit_cmd_out_zero", {16'd0, cmd_out[0]}, 32'd0);

        // Temperature load and mid-frame update
        load_temp(0, 16'h1A50);
        do_frame(0, 16, 16'h0000, 1'b0, 16'h0000);
        chk("lit_temp_1a50", {16'd0, last_rd}, 32'h0000_1A50);
        do_frame(0, 16, 16'h0000, 1'b1, 16'h0F00);
        chk("lit_mid_update_old", {16'd0, last_rd}, 32'h0000_1A50);
        do_frame(0, 16, 16'h0000, 1'b0, 16'h0000);
        chk("lit_mid_update_new", {16'd0, last_rd}, 32'h0000_0F00);

        // Shutdown command, ID readback, then wake
        do_frame(0, 32, 16'h00FF, 1'b0, 16'h0000);
        chk("lit_shutdown_set", {31'd0, shutdown[0]}, 32'd1);
        chk("lit_cmd_00ff", {16'd0, cmd_out[0]}, 32'h0000_00FF);
        do_frame(0, 16, 16'h0000, 1'b0, 16'h0000);
        chk("lit_id_code", {16'd0, last_rd}, 32'h0000_8001);
        do_frame(0, 32, 16'h0000, 1'b0, 16'h0000);
        chk("lit_id_during_wake", {16'd0, last_rd}, 32'h0000_8001);
        chk("lit_shutdown_clr", {31'd0, shutdown[0]}, 32'd0);
        do_frame(0, 16, 16'h0000, 1'b0, 16'h0000);
        chk("lit_temp_after_wake", {16'd0, last_rd}, 32'h0000_0F00);

        // Partial command and aborted data phase
        do_frame(0, 32, 16'h00FF, 1'b0, 16'h0000);
        do_frame(0, 24, 16'h0000, 1'b0, 16'h0000);
        chk("lit_partial_keeps_sd", {31'd0, shutdown[0]}, 32'd1);
        chk("lit_partial_cv_count", cv_cnt[0], 32'd3);
        do_frame(0, 8, 16'h0000, 1'b0, 16'h0000);
        do_frame(0, 32, 16'h0000, 1'b0, 16'h0000);
        chk("lit_after_abort_id", {16'd0, last_rd}, 32'h0000_8001);

        // All four SPI modes
        for (int m = 0; m < 4; m++) begin
            load_temp(m, 16'hA5C3);
            do_frame(m, 32, 16'h0000, 1'b0, 16'h0000);
            chk($sformatf("lit_mode%0d_a5c3", m), {16'd0, last_rd}, 32'h0000_A5C3);
        end

        // Reset at data bit 7 with CS held low
        do_frame(0, 32, 16'h00FF, 1'b0, 16'h0000);
        @(negedge clk);
        cs[0] = 1'b0;
        half();
        for (int i = 0; i < 7; i++) begin
            sck[0] = 1'b1;
            half();
            sck[0] = 1'b0;
            half();
        end
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_mid_so", {31'd0, so[0]}, 32'd0);
        chk("rst_mid_so_oe", {31'd0, so_oe[0]}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_mid_shutdown", {31'd0, shutdown[0]}, 32'd0);
        chk("rst_mid_cmd_out", {16'd0, cmd_out[0]}, 32'd0);
        chk("rst_mid_cmd_valid", {31'd0, cmd_valid[0]}, 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sck[0] = 1'b1;
            half();
            chk("post_rst_so_hi", {31'd0, so[0]}, 32'd0);
            chk("post_rst_busy_hi", {31'd0, busy[0]}, 32'd0);
            sck[0] = 1'b0;
            half();
            chk("post_rst_so_lo", {31'd0, so[0]}, 32'd0);
            chk("post_rst_so_oe", {31'd0, so_oe[0]}, 32'd0);
        end
        cs[0] = 1'b1;
        repeat (6) @(negedge clk);
        do_frame(0, 16, 16'h0000, 1'b0, 16'h0000);
        chk("lit_post_rst_temp", {16'd0, last_rd}, 32'h0000_44C0);

        chk_en = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_temp_sensor_slave.md
Name: spi_temp_sensor_slave

Overview:
- Synthesizable, parametrised successor to the team's fixed-value LM70-style SPI temperature sensor model.
- Runs on a system clock and oversamples CS/SCK/SI through synchronisers.
- Serves a live temperature snapshot, MSB first, then accepts a host command word. The command can place the device in shutdown, where reads return an ID code.
- Sits behind the SPI master in the sensor subsystem, both as a bench model and as an on-chip emulated sensor.

Parameters:
- DATA_W, 16, bits shifted out per frame (temperature/ID word).
- CMD_W, 16, bits shifted in after the data word.
- TEMP_RESET, 16'h44C0, temperature register reset value (width DATA_W).
- ID_CODE, 16'h8001, word returned instead of temperature while in shutdown.
- SHUTDOWN_CMD, 16'h00FF, complete command value that enters shutdown.
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = launch on CS fall/trailing edge, sample on leading edge; 1 = launch on leading edge, sample on trailing edge.
- SYNC_STAGES, 2, synchroniser depth for CS, SCK, SI (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x SCK frequency.
- rst_n  input  1  asynchronous active-low reset.
- CS  input  1  SPI chip select, active low, asynchronous to clk.
- SCK  input  1  SPI serial clock, asynchronous to clk.
- SI  input  1  serial data from host.
- SO  output  1  serial data to host.
- SO_OE  output  1  SO drive enable; high while the synchronised CS is low.
- temp_in  input  DATA_W  new temperature value.
- temp_valid  input  1  one-clk strobe that loads temp_in into the temperature register.
- shutdown  output  1  device is in shutdown.
- cmd_out  output  CMD_W  last complete command received.
- cmd_valid  output  1  one-clk pulse when cmd_out updates.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (async assert, sync release via clk):
  - SO=0, SO_OE=0, shutdown=0, cmd_out=0, cmd_valid=0, busy=0.
  - Temperature register = TEMP_RESET; state = IDLE; bit counter = 0.
- Synchronisation:
  - CS, SCK, SI each pass through SYNC_STAGES flops.
  - The effective clock is synchronised SCK XOR CPOL.
  - Leading edge = effective 0->1; trailing edge = effective 1->0. Edges are detected by comparison with the previous sample.
  - Outputs change 1 clk after the synchronised edge, i.e. SYNC_STAGES+1 clk after the pin edge.
- Temperature register:
  - Loads temp_in on temp_valid, at any time.
  - A frame uses the snapshot taken at CS fall. An update during a frame affects the next frame only.
  - When temp_valid coincides with the synchronised CS fall, the snapshot uses the old value.
- States:
  - IDLE: waits for synchronised CS fall. On the fall, shift_out <= shutdown ? ID_CODE : temp_reg, bit counter = 0, go to DATA. For CPHA=0, SO = MSB immediately.
  - DATA:
    - Sample edge increments the bit counter.
    - Launch edge shifts shift_out left, filling with 0. SO = shift_out[DATA_W-1]. For CPHA=1, the first leading edge presents the MSB without shifting.
    - After DATA_W sample edges, go to CMD with the counter cleared.
  - CMD:
    - SO=0.
    - Each sample edge shifts SI into cmd_shift, LSB entry, MSB-first order.
    - After CMD_W samples, go to DONE.
  - DONE: SO=0; further SCK edges are ignored.
- CS rise (synchronised), in any state:
  - Go to IDLE; SO_OE=0; SO=0.
  - If leaving DONE: cmd_out <= cmd_shift and cmd_valid pulses for 1 clk. shutdown <= (cmd_shift == SHUTDOWN_CMD). Any other complete command clears shutdown.
  - A partial command, or a rise during DATA, leaves cmd_out, shutdown and cmd_valid untouched.
- SCK edges while CS is high are ignored.
- A glitch shorter than SYNC_STAGES clk is not guaranteed to be filtered.
- Reset mid-frame:
  - Frame abandoned and all outputs return to reset values.
  - Even if CS is still low, no frame starts until a new CS fall is seen.
- shutdown takes effect on the next frame's snapshot, never the current one.

Test Plan:
- Reset, no temp_valid, mode 0 frame of 16 data clocks with SI=0 -> SO sequence 0x44C0 MSB first; cmd_out stays 0; shutdown=0.
- temp_valid with temp_in=0x1A50, then a frame -> 0x1A50. temp_valid=0x0F00 pulsed mid-frame -> current frame still 0x1A50; next frame 0x0F00.
- Frame with 32 clocks, SI=0x00FF in the command phase -> cmd_valid pulse, cmd_out=0x00FF, shutdown=1. Next frame reads 0x8001. A frame with command 0x0000 -> shutdown=0 and the following read returns temperature.
- Command phase aborted after 8 bits (CS rise) -> no cmd_valid; shutdown unchanged. CS rise mid-DATA -> state IDLE and SO_OE=0.
- Sweep CPOL/CPHA over all 4 modes with reading 0xA5C3 -> host sampling on the mode's sample edge recovers 0xA5C3 in every mode.
- rst_n asserted at data bit 7 with CS held low -> outputs at reset values immediately. SCK edges before a new CS fall do not move SO. The next frame after the CS fall reads 0x44C0.
